// File: rtl/des_round_key_gen.sv
// DES key schedule: rotates PC-1 halves and applies PC-2, one round key per handshake.
// Optional macro DES_KEYGEN_ZEROIZE_EN clears C/D and round_key on completion.
module des_round_key_gen #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] pc1_key,
    input  logic        rk_ready,
    output logic        rk_valid,
    output logic [47:0] round_key,
    output logic [3:0]  round_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE,
        GEN
    } state_t;

    localparam logic [3:0] LAST_RN = 4'(NUM_ROUNDS - 1);

    localparam logic [287:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // First table entry sits in the MSBs, so entry k is at slot 47-k.
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [5:0] src;
        pc2 = '0;
        for (int k = 0; k < 48; k++) begin
            src = PC2_TAB[(47 - k) * 6 +: 6] - 6'd1;
            pc2[k] = cd[src];
        end
    endfunction

    function automatic logic [1:0] shift_of(input logic [4:0] rnd);
        case (rnd)
            5'd1, 5'd2, 5'd9, 5'd16: shift_of = 2'd1;
            default:                 shift_of = 2'd2;
        endcase
    endfunction

    // DES bit 1 lives at index 0, so a DES left rotate moves bits toward index 0.
    function automatic logic [27:0] rotl28(input logic [27:0] h,
                                           input logic [1:0] s);
        if (s == 2'd1) rotl28 = {h[0], h[27:1]};
        else           rotl28 = {h[1:0], h[27:2]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h,
                                           input logic [1:0] s);
        if (s == 2'd1) rotr28 = {h[26:0], h[27]};
        else           rotr28 = {h[25:0], h[27:26]};
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd,
                                            input logic [1:0] s);
        rotl_cd = {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd,
                                            input logic [1:0] s);
        rotr_cd = {rotr28(cd[55:28], s), rotr28(cd[27:0], s)};
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [55:0] cd_q;
    logic [55:0] cd_d;
    logic        dec_q;
    logic        dec_d;
    logic [47:0] key_d;
    logic [3:0]  rnum_d;
    logic        valid_d;
    logic        busy_d;
    logic        done_d;
    logic        last_hs;
    logic [4:0]  rnd_fwd;
    logic [4:0]  rnd_rev;

    assign last_hs = dec_q ? (round_num == 4'd0) : (round_num == LAST_RN);
    assign rnd_fwd = {1'b0, round_num} + 5'd2;
    assign rnd_rev = {1'b0, round_num} + 5'd1;

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        dec_d   = dec_q;
        key_d   = round_key;
        rnum_d  = round_num;
        valid_d = rk_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d   = decrypt;
                    cd_d    = decrypt ? pc1_key : rotl_cd(pc1_key, 2'd1);
                    key_d   = pc2(cd_d);
                    rnum_d  = decrypt ? LAST_RN : 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (rk_valid && rk_ready) begin
                    if (last_hs) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef DES_KEYGEN_ZEROIZE_EN
                        cd_d    = '0;
                        key_d   = '0;
`endif
                    end else if (dec_q) begin
                        cd_d   = rotr_cd(cd_q, shift_of(rnd_rev));
                        key_d  = pc2(cd_d);
                        rnum_d = round_num - 4'd1;
                    end else begin
                        cd_d   = rotl_cd(cd_q, shift_of(rnd_fwd));
                        key_d  = pc2(cd_d);
                        rnum_d = round_num + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cd_q      <= '0;
            dec_q     <= 1'b0;
            round_key <= '0;
            round_num <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            dec_q     <= dec_d;
            round_key <= key_d;
            round_num <= rnum_d;
            rk_valid  <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_des_round_key_gen.sv
// Directed bench for des_round_key_gen using the classic 133457799BBCDFF1 key.
// Vectors are written in DES bit order and bit-reversed onto the buses.
module tb_des_round_key_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] pc1_key;
    logic        rk_ready;
    logic        rk_valid;
    logic [47:0] round_key;
    logic [3:0]  round_num;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    localparam logic [55:0] PC1 = 56'hF0CCAAF556678F;
    localparam logic [47:0] KEYS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_round_key_gen #(.NUM_ROUNDS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
        .pc1_key   (pc1_key),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_num (round_num),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] rev48(input logic [47:0] x);
        for (int k = 0; k < 48; k++) rev48[k] = x[47 - k];
    endfunction

    function automatic logic [55:0] rev56(input logic [55:0] x);
        for (int k = 0; k < 56; k++) rev56[k] = x[55 - k];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: ready held high; 1: random ready with a 5-cycle stall at key 3;
    // 2: ready high with a stray start carrying a different key mid-schedule.
    task automatic run_sched(input logic dec, input int mode,
                             output int hs, output int cyc);
        int  stall;
        int  idx;
        logic acc;
        logic injected;
        hs = 0;
        cyc = 0;
        stall = 0;
        injected = 1'b0;
        while (hs < 16 && cyc < 400) begin
            idx = dec ? 15 - hs : hs;
            chk("valid", 64'(rk_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("key", 64'(round_key), 64'(rev48(KEYS[idx])));
            chk("round_num", 64'(round_num), 64'(idx));
            start = 1'b0;
            pc1_key = rev56(PC1);
            decrypt = dec;
            if (mode == 1) begin
                if (hs == 2 && stall < 5) begin
                    rk_ready = 1'b0;
                    stall++;
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                rk_ready = 1'b1;
            end
            if (mode == 2 && hs == 4 && !injected) begin
                start = 1'b1;
                pc1_key = rev56(PC1 ^ 56'h0123456789ABCD);
                decrypt = ~dec;
                injected = 1'b1;
            end
            acc = rk_ready;
            tick();
            cyc++;
            if (acc) hs++;
        end
        start = 1'b0;
        pc1_key = rev56(PC1);
        chk("handshakes", 64'(hs), 64'd16);
    endtask

    task automatic post(input logic [47:0] last_key);
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_drop", 64'(rk_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
`ifdef DES_KEYGEN_ZEROIZE_EN
        chk("key_after", 64'(round_key), 64'd0);
`else
        chk("key_after", 64'(round_key), 64'(rev48(last_key)));
`endif
    endtask

    initial begin
        int hs;
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        pc1_key = '0;
        rk_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(rk_valid), 64'd0);
        chk("rst_key", 64'(round_key), 64'd0);
        chk("rst_rnum", 64'(round_num), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_valid", 64'(rk_valid), 64'd0);

        // encrypt, ready always high
        pc1_key = rev56(PC1);
        decrypt = 1'b0;
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sched(1'b0, 0, hs, cyc);
        chk("enc_cycles", 64'(cyc), 64'd16);
        post(KEYS[15]);
        tick();
        chk("done_once", 64'(done), 64'd0);

        // decrypt
        decrypt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sched(1'b1, 0, hs, cyc);
        chk("dec_cycles", 64'(cyc), 64'd16);
        post(KEYS[0]);
        tick();
        chk("done_once_dec", 64'(done), 64'd0);

        // backpressure
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sched(1'b0, 1, hs, cyc);
        post(KEYS[15]);

        // start in the done cycle is accepted; stray start later is ignored
        rk_ready = 1'b1;
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sched(1'b0, 2, hs, cyc);
        post(KEYS[15]);
        tick();
        chk("done_once_ign", 64'(done), 64'd0);

        // reset after the 7th handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        rk_ready = 1'b1;
        repeat (7) tick();
        chk("pre_rst_rnum", 64'(round_num), 64'd7);
        chk("pre_rst_key", 64'(round_key), 64'(rev48(KEYS[7])));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(rk_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_key", 64'(round_key), 64'd0);
        chk("mid_rst_rnum", 64'(round_num), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_valid", 64'(rk_valid), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sched(1'b0, 0, hs, cyc);
        post(KEYS[15]);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
